// File: rtl/vx_om_pkg.sv
// Shared types and constants for the OM memory responder: response payload,
// default queue depth and the pending-counter width helper.
package vx_om_pkg;

  localparam int OM_DATA_WIDTH     = 32;
  localparam int OM_TAG_WIDTH      = 8;
  localparam int OM_RSP_QUEUE_SIZE = 4;

  typedef struct packed {
    logic [OM_DATA_WIDTH-1:0] data;
    logic [OM_TAG_WIDTH-1:0]  tag;
  } om_mem_rsp_t;

  // Counter must hold 0..queue_size inclusive.
  function automatic int om_pending_width(input int queue_size);
    return $clog2(queue_size) + 1;
  endfunction

endpackage

// File: rtl/vx_om_rsp_fifo.sv
// Show-ahead response FIFO; head is visible without a pop, and the output
// holds the last presented entry while empty (0 after reset).
module vx_om_rsp_fifo
  import vx_om_pkg::*;
#(
  parameter type T     = om_mem_rsp_t,
  parameter int  DEPTH = OM_RSP_QUEUE_SIZE
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     dout,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        full;
  T            slots [DEPTH];
  T            last_q;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = empty ? last_q : slots[rd_ptr[AW-1:0]];

  // NOTE: storage arrays carry no reset; only pointers and the hold register do.
  always_ff @(posedge clk) begin
    if (push && !full) slots[wr_ptr[AW-1:0]] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      last_q <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (!empty) begin
        last_q <= slots[rd_ptr[AW-1:0]];
        if (pop) rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vx_om_mem_responder.sv
// OM memory-side responder: local tile store, fixed-latency read pipe, credit
// limited in-order responses. VX_OM_RSP_WRITE_ACK_EN makes writes respond too.
module vx_om_mem_responder
  import vx_om_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = OM_DATA_WIDTH,
  parameter int TAG_WIDTH      = OM_TAG_WIDTH,
  parameter int MEM_WORDS_LOG2 = 10,
  parameter int LATENCY        = 2,
  parameter int RSP_QUEUE_SIZE = OM_RSP_QUEUE_SIZE,
  localparam int PEND_W        = om_pending_width(RSP_QUEUE_SIZE),
  localparam int BYTES         = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_rw,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [BYTES-1:0]      req_byteen,
  input  logic [DATA_WIDTH-1:0] req_data,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  output logic                  req_ready,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [TAG_WIDTH-1:0]  rsp_tag,
  input  logic                  rsp_ready,
  output logic                  err_oob,
  output logic [PEND_W-1:0]     pending
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [TAG_WIDTH-1:0]  tag;
  } rsp_t;

  localparam int MEM_WORDS = 1 << MEM_WORDS_LOG2;
  localparam logic [ADDR_WIDTH-1:0] HI_MASK  = {ADDR_WIDTH{1'b1}} << MEM_WORDS_LOG2;
  localparam logic [PEND_W-1:0]     CREDITS  = PEND_W'(RSP_QUEUE_SIZE);

  logic [DATA_WIDTH-1:0]     store [MEM_WORDS];
  logic [MEM_WORDS_LOG2-1:0] word_idx;
  logic                      req_fire;
  logic                      rsp_fire;
  logic                      oob;
  logic                      in_vld;
  rsp_t                      in_rsp;
  logic                      fifo_push;
  rsp_t                      fifo_in;
  rsp_t                      fifo_out;
  logic                      fifo_empty;

  // Ready comes from the registered count only, so a response fire frees
  // its credit one cycle later.
  assign req_ready = (pending < CREDITS);
  assign req_fire  = req_valid && req_ready;
  assign rsp_fire  = rsp_valid && rsp_ready;
  assign oob       = |(req_addr & HI_MASK);
  assign word_idx  = req_addr[MEM_WORDS_LOG2-1:0];

  always_ff @(posedge clk) begin
    if (req_fire && req_rw && !oob) begin
      for (int b = 0; b < BYTES; b++) begin
        if (req_byteen[b]) store[word_idx][8*b +: 8] <= req_data[8*b +: 8];
      end
    end
  end

`ifdef VX_OM_RSP_WRITE_ACK_EN
  assign in_vld = req_fire;
`else
  assign in_vld = req_fire && !req_rw;
`endif

  // NOTE: defaults first in combinational blocks so no path infers a latch.
  always_comb begin
    in_rsp     = '0;
    in_rsp.tag = req_tag;
    if (!req_rw && !oob) in_rsp.data = store[word_idx];
  end

  if (LATENCY == 1) begin : g_no_pipe
    assign fifo_push = in_vld;
    assign fifo_in   = in_rsp;
  end else begin : g_pipe
    localparam int STAGES = LATENCY - 1;
    logic [STAGES-1:0] vld_q;
    rsp_t              data_q [STAGES];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        vld_q <= '0;
        for (int i = 0; i < STAGES; i++) data_q[i] <= '0;
      end else begin
        vld_q[0]  <= in_vld;
        data_q[0] <= in_rsp;
        for (int i = 1; i < STAGES; i++) begin
          vld_q[i]  <= vld_q[i-1];
          data_q[i] <= data_q[i-1];
        end
      end
    end

    assign fifo_push = vld_q[STAGES-1];
    assign fifo_in   = data_q[STAGES-1];
  end

  vx_om_rsp_fifo #(
    .T     (rsp_t),
    .DEPTH (RSP_QUEUE_SIZE)
  ) u_rsp_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (fifo_in),
    .pop   (rsp_ready),
    .dout  (fifo_out),
    .empty (fifo_empty)
  );

  assign rsp_valid = !fifo_empty;
  assign rsp_data  = fifo_out.data;
  assign rsp_tag   = fifo_out.tag;

  // Credits cover pipe plus queue occupancy, so neither can overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
      err_oob <= 1'b0;
    end else begin
      case ({in_vld, rsp_fire})
        2'b10:   pending <= pending + 1'b1;
        2'b01:   pending <= pending - 1'b1;
        default: pending <= pending;
      endcase
      if (req_fire && oob) err_oob <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vx_om_mem_responder.sv
// Scoreboard bench for vx_om_mem_responder: a reference store model predicts
// each response at acceptance; a negedge monitor pops and compares on fire.
module tb_vx_om_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_rw = 1'b0;
  logic [15:0] req_addr = '0;
  logic [3:0]  req_byteen = '0;
  logic [31:0] req_data = '0;
  logic [7:0]  req_tag = '0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [7:0]  rsp_tag;
  logic        rsp_ready = 1'b0;
  logic        err_oob;
  logic [2:0]  pending;

  vx_om_mem_responder dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_rw     (req_rw),
    .req_addr   (req_addr),
    .req_byteen (req_byteen),
    .req_data   (req_data),
    .req_tag    (req_tag),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_tag    (rsp_tag),
    .rsp_ready  (rsp_ready),
    .err_oob    (err_oob),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  tag;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] model_mem [int];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Response monitor: a fire is sampled at negedge; rsp_ready only changes
  // just after posedge so the sample matches the following edge.
  always @(negedge clk) begin
    if (reset && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", rsp_valid, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_data", rsp_data, e.data);
        check("rsp_tag", rsp_tag, e.tag);
      end
    end
  end

  // Drives one request from posedge+1, returns at posedge+1 after acceptance.
  task automatic do_req(input logic rw, input logic [15:0] addr, input logic [3:0] be,
                        input logic [31:0] data, input logic [7:0] tag, output int waited);
    bit   is_oob;
    exp_t e;
    logic [31:0] cur;
    req_valid  = 1'b1;
    req_rw     = rw;
    req_addr   = addr;
    req_byteen = be;
    req_data   = data;
    req_tag    = tag;
    waited     = 0;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      waited++;
      if (waited > 50) begin
        check("req_ready_timeout", req_ready, 1'b1);
        req_valid = 1'b0;
        return;
      end
    end
    is_oob = (addr >= 16'd1024);
    cur    = model_mem.exists(int'(addr)) ? model_mem[int'(addr)] : 32'h0;
    if (rw) begin
      if (!is_oob) begin
        for (int b = 0; b < 4; b++) if (be[b]) cur[8*b +: 8] = data[8*b +: 8];
        model_mem[int'(addr)] = cur;
      end
`ifdef VX_OM_RSP_WRITE_ACK_EN
      e.data = 32'h0;
      e.tag  = tag;
      sb.push_back(e);
`endif
    end else begin
      e.data = is_oob ? 32'h0 : cur;
      e.tag  = tag;
      sb.push_back(e);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_pending", pending, 3'd0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data", rsp_data, 32'h0);
    check("rst_rsp_tag", rsp_tag, 8'h0);
    check("rst_err_oob", err_oob, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 1'b1);

    // 1: full write, read latency and hold while stalled
    do_req(1'b1, 16'd5, 4'hF, 32'hAABBCCDD, 8'h10, w);
    drain();
    rsp_ready = 1'b0;
    do_req(1'b0, 16'd5, 4'h0, 32'h0, 8'h11, w);
    @(negedge clk);
    check("lat_t1_valid", rsp_valid, 1'b0);
    @(negedge clk);
    check("lat_t2_valid", rsp_valid, 1'b1);
    check("lat_t2_data", rsp_data, 32'hAABBCCDD);
    @(negedge clk);
    check("hold_data", rsp_data, 32'hAABBCCDD);
    check("hold_tag", rsp_tag, 8'h11);
    drain();

    // 2: partial write, then empty FIFO keeps the last response on the bus
    do_req(1'b1, 16'd5, 4'h3, 32'h00001234, 8'h12, w);
    do_req(1'b0, 16'd5, 4'h0, 32'h0, 8'h13, w);
    drain();
    repeat (2) @(negedge clk);
    check("empty_valid", rsp_valid, 1'b0);
    check("empty_hold_data", rsp_data, 32'hAABB1234);
    check("empty_hold_tag", rsp_tag, 8'h13);
    @(posedge clk);
    #1;

    // 3: credit exhaustion and return
    rsp_ready = 1'b0;
    for (int t = 1; t <= 4; t++) do_req(1'b0, 16'd5, 4'h0, 32'h0, 8'(t), w);
    fork
      begin
        do_req(1'b0, 16'd5, 4'h0, 32'h0, 8'd5, w);
        check("tag5_wait_cycles", w, 2);
      end
      begin
        @(negedge clk);
        check("full_req_ready", req_ready, 1'b0);
        check("full_pending", pending, 3'd4);
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        check("fire_cycle_req_ready", req_ready, 1'b0);
        @(negedge clk);
        check("credit_back_pending", pending, 3'd3);
      end
    join
    drain();

    // 4: out-of-range accesses
    do_req(1'b1, 16'd0, 4'hF, 32'h01020304, 8'h20, w);
    drain();
    check("oob_clear", err_oob, 1'b0);
    do_req(1'b0, 16'h0400, 4'h0, 32'h0, 8'h22, w);
    drain();
    check("oob_set", err_oob, 1'b1);
    do_req(1'b1, 16'h0400, 4'hF, 32'hFFFFFFFF, 8'h23, w);
    do_req(1'b0, 16'd0, 4'h0, 32'h0, 8'h24, w);
    do_req(1'b0, 16'h8005, 4'h0, 32'h0, 8'h25, w);
    drain();
    check("oob_sticky", err_oob, 1'b1);

    // 5: back-to-back reads, steady state
    for (int i = 0; i < 8; i++)
      do_req(1'b1, 16'(16 + i), 4'hF, 32'h11111111 * (i + 1) + 32'h0F0, 8'h40, w);
    drain();
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          do_req(1'b0, 16'(16 + i), 4'h0, 32'h0, 8'(8'h50 + i), w);
          check("b2b_wait", w, 0);
        end
      end
      begin
        repeat (3) @(negedge clk);
        for (int k = 0; k < 7; k++) begin
          check("b2b_pending", pending, 3'd2);
          if (k < 6) @(negedge clk);
        end
      end
    join
    drain();

    // 6: reset with reads in flight
    rsp_ready = 1'b0;
    for (int t = 0; t < 3; t++) do_req(1'b0, 16'd5, 4'h0, 32'h0, 8'(8'h61 + t), w);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_rsp_valid", rsp_valid, 1'b0);
    check("mid_rst_pending", pending, 3'd0);
    check("mid_rst_err_oob", err_oob, 1'b0);
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("no_stale_rsp", rsp_valid, 1'b0);
    end
    check("post_rst_tag", rsp_tag, 8'h0);
    @(posedge clk);
    #1;
`ifdef VX_OM_RSP_WRITE_ACK_EN
    do_req(1'b1, 16'd5, 4'hF, 32'hCAFEF00D, 8'h33, w);
    drain();
`endif
    do_req(1'b0, 16'd5, 4'h0, 32'h0, 8'h70, w);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vx_om_mem_responder.md
Name: vx_om_mem_responder

Overview:
- Memory-side responder for the OM output-merger request path: it terminates one channel of the OM cache request/response protocol.
- Backed by a local word-addressed tile store.
- Used as the framebuffer/depth-buffer endpoint for OM unit-level benches and as a small on-chip tile buffer.
- Serves byte-masked writes and tagged reads with fixed pipeline latency, credit-limited outstanding reads and ordered responses.

Parameters:
- ADDR_WIDTH, 16, word address width of req_addr.
- DATA_WIDTH, 32, word width; byteen is DATA_WIDTH/8.
- TAG_WIDTH, 8, request/response tag width.
- MEM_WORDS_LOG2, 10, log2 of store depth in words.
- LATENCY, 2, cycles from read acceptance to earliest rsp_valid (>=1).
- RSP_QUEUE_SIZE, 4, max outstanding responses (power of two, >=2).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request valid
- req_rw  in  1  1=write, 0=read
- req_addr  in  ADDR_WIDTH  word address
- req_byteen  in  DATA_WIDTH/8  write byte enables
- req_data  in  DATA_WIDTH  write data
- req_tag  in  TAG_WIDTH  request tag
- req_ready  out  1  request accepted when req_valid&&req_ready
- rsp_valid  out  1  response valid
- rsp_data  out  DATA_WIDTH  read data
- rsp_tag  out  TAG_WIDTH  tag of the originating request
- rsp_ready  in  1  response consumed when rsp_valid&&rsp_ready
- err_oob  out  1  sticky flag: an out-of-range address was accepted
- pending  out  $clog2(RSP_QUEUE_SIZE)+1  responses in flight (pipe + queue)

Behaviour:
- Reset (reset low, async assert, sync deassert):
  - pending=0, rsp_valid=0, rsp_data=0, rsp_tag=0, err_oob=0.
  - req_ready=1 from the first cycle after deassert.
  - Store contents are not reset.
- req_ready = (pending < RSP_QUEUE_SIZE). It applies to reads and writes alike.
- Acceptance cycle T, write:
  - Store updated at the T clock edge, per byte where byteen=1.
  - byteen=0 is a legal no-op.
  - No response.
- Acceptance cycle T, read:
  - Store read at T; a same-cycle earlier write is already visible (write-first is not applicable; ordering is by acceptance).
  - Data and tag enter a LATENCY-1 stage register pipe, then the response FIFO.
  - The FIFO is fall-through when empty, so rsp_valid rises at T+LATENCY at the earliest.
- Responses return strictly in acceptance order. rsp_data/rsp_tag are held stable while rsp_valid && !rsp_ready.
- pending:
  - +1 on read accept, -1 on response fire.
  - Both in the same cycle: unchanged.
  - Never exceeds RSP_QUEUE_SIZE, so the FIFO cannot overflow and the pipe never stalls.
- Out-of-range: any set req_addr bit at or above MEM_WORDS_LOG2.
  - Write dropped.
  - Read returns data 0 with its tag.
  - err_oob set and held until reset.
- Empty FIFO: rsp_valid=0, and rsp_data/rsp_tag hold their last value (0 after reset).
- Full credits with rsp fire in the same cycle: req_ready stays 0 that cycle (no combinational ready-from-rsp path). Credit is visible next cycle.
- Reset mid-operation: in-flight reads and queued responses are discarded. No response is emitted for them.

Optional Feature:
- Macro: VX_OM_RSP_WRITE_ACK_EN.
- Defined:
  - Writes also produce a response (rsp_data=0, rsp_tag=req_tag) through the same pipe and FIFO, in order with reads.
  - Writes consume a credit and count in pending.
  - An out-of-range write is still acknowledged.
- Undefined: writes produce no response and do not affect pending.

Decomposition:
- Shared in VX_om_pkg:
  - om_mem_rsp_t struct {data, tag}.
  - OM_RSP_QUEUE_SIZE default constant.
  - Helper function for the pending counter width.
- One natural sub-module: vx_om_rsp_fifo.
  - Fall-through FIFO of om_mem_rsp_t, depth RSP_QUEUE_SIZE.
  - Full/empty flags; pointer wrap uses an extra MSB.
- The top level holds the store, the latency pipe, credit logic and err_oob.

Test Plan:
1. Write addr 5 data 0xAABBCCDD byteen 0xF, then read addr 5 tag 0x11 at T → rsp_valid at T+2, data 0xAABBCCDD, tag 0x11.
2. Partial write byteen 0x3 data 0x00001234 over 0xAABBCCDD, then read → 0xAABB1234.
3. rsp_ready held 0, issue 5 reads tags 1..5:
   - req_ready drops after 4 accepts; pending=4.
   - Raise rsp_ready → tags 1,2,3,4 in order.
   - Tag 5 is accepted the cycle after the first fire.
4. Read addr 0x0400 (MEM_WORDS_LOG2=10), tag 0x22 → data 0, tag 0x22, err_oob=1 sticky. A write to 0x0400 leaves addr 0 unchanged.
5. Back-to-back reads with rsp_ready=1 every cycle → one response per cycle, pending constant at 2, req_ready never drops.
6. Assert reset with 3 reads outstanding → rsp_valid=0, pending=0 immediately; after release, no stale responses appear. With VX_OM_RSP_WRITE_ACK_EN, a write tag 0x33 yields rsp data 0, tag 0x33.
